julia_coord_gen: RTL and testbench

Pixel-coordinate generator for the Julia-set renderer. It consumes the HPS-written view parameters (`x_0`, `x_step`, `y_0`, `y_step`) exported from `Computer_System`. On each frame start it latches them atomically, then streams one complex-plane coordinate per pixel in raster order to the iteration engines over a valid/ready handshake. It sits between the Qsys PIO exports and the iterator array, in the fabric clock domain.

---
 rtl/julia_coord_gen.sv | 142 ++++++++++++++
 tb/tb_julia_coord_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/julia_coord_gen.sv
// Julia-set pixel coordinate generator: latches view parameters at frame start, streams
// (x, y, col, row) in raster order. Optional JULIA_COORD_AUTO_RESTART_EN loops frames continuously.
module julia_coord_gen #(
    parameter int WIDTH = 27,
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int COL_W = 10,
    parameter int ROW_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x_0,
    input  logic [WIDTH-1:0] x_step,
    input  logic [WIDTH-1:0] y_0,
    input  logic [WIDTH-1:0] y_step,
    input  logic             start,
    output logic             busy,
    output logic             frame_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [COL_W-1:0] out_col,
    output logic [ROW_W-1:0] out_row,
    output logic             out_last
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x0_sh_q, x0_sh_d, xs_sh_q, xs_sh_d;
    logic [WIDTH-1:0] ys_sh_q, ys_sh_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             load;

    always_comb begin
        state_d      = state_q;
        x0_sh_d      = x0_sh_q;
        xs_sh_d      = xs_sh_q;
        ys_sh_d      = ys_sh_q;
        x_d          = x_q;
        y_d          = y_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        load         = 1'b0;

        case (state_q)
            IDLE: load = start;
            RUN: begin
                if (out_ready) begin
                    if (col_q != COL_LAST) begin
                        col_d = col_q + 1'b1;
                        x_d   = x_q + xs_sh_q;
                    end else if (row_q != ROW_LAST) begin
                        // x re-seeded from the latch so column error never crosses rows
                        col_d = '0;
                        row_d = row_q + 1'b1;
                        x_d   = x0_sh_q;
                        y_d   = y_q + ys_sh_q;
                    end else begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                    end
                end
            end
            DONE: begin
`ifdef JULIA_COORD_AUTO_RESTART_EN
                load = 1'b1;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        // y_0 needs no shadow: it is consumed only at the load itself
        if (load) begin
            x0_sh_d = x_0;
            xs_sh_d = x_step;
            ys_sh_d = y_step;
            x_d     = x_0;
            y_d     = y_0;
            col_d   = '0;
            row_d   = '0;
            state_d = RUN;
        end

        out_valid_d = (state_d == RUN);
        busy_d      = (state_d != IDLE);
        out_last_d  = (state_d == RUN) && (col_d == COL_LAST) && (row_d == ROW_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            x0_sh_q      <= '0;
            xs_sh_q      <= '0;
            ys_sh_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            col_q        <= '0;
            row_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x0_sh_q      <= x0_sh_d;
            xs_sh_q      <= xs_sh_d;
            ys_sh_q      <= ys_sh_d;
            x_q          <= x_d;
            y_q          <= y_d;
            col_q        <= col_d;
            row_q        <= row_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign out_valid  = out_valid_q;
    assign out_x      = x_q;
    assign out_y      = y_q;
    assign out_col    = col_q;
    assign out_row    = row_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_julia_coord_gen.sv
// Directed bench for julia_coord_gen on a 4x3 frame; expected coordinates come from
// x_0 + col*x_step, y_0 + row*y_step (mod 2^27).
module tb_julia_coord_gen;

    localparam int WIDTH = 27;
    localparam int NPIX  = 12;

    logic             clk = 1'b0;
    logic             reset, start, out_ready;
    logic [WIDTH-1:0] x_0, x_step, y_0, y_step;
    logic             busy, frame_done, out_valid, out_last;
    logic [WIDTH-1:0] out_x, out_y;
    logic [1:0]       out_col, out_row;

    int checks = 0;
    int errors = 0;

    julia_coord_gen #(.WIDTH(WIDTH), .H_RES(4), .V_RES(3), .COL_W(2), .ROW_W(2)) dut (
        .clk(clk), .reset(reset), .x_0(x_0), .x_step(x_step), .y_0(y_0), .y_step(y_step),
        .start(start), .busy(busy), .frame_done(frame_done), .out_valid(out_valid),
        .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_col(out_col),
        .out_row(out_row), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fdone"}, frame_done, 0);
        check({tag, "_last"}, out_last, 0);
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at the negedge where pixel (0,0) should be showing; leaves at the DONE cycle.
    task automatic collect_frame(input bit bp, input bit poke, input logic [WIDTH-1:0] ex0,
                                 input logic [WIDTH-1:0] exs, input logic [WIDTH-1:0] ey0,
                                 input logic [WIDTH-1:0] eys);
        int beat = 0;
        int cyc  = 0;
        int col, row;
        bit r;
        while (beat < NPIX && cyc < 400) begin
            col = beat % 4;
            row = beat / 4;
            check("valid", out_valid, 1);
            check("busy", busy, 1);
            check("fdone_mid", frame_done, 0);
            check("x", out_x, WIDTH'(ex0 + WIDTH'(col) * exs));
            check("y", out_y, WIDTH'(ey0 + WIDTH'(row) * eys));
            check("col", out_col, col);
            check("row", out_row, row);
            check("last", out_last, (beat == NPIX - 1));
            if (poke && beat == 5) begin
                x_0   = 27'h0223456;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = r;
            if (r) beat++;
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check("frame_len", beat, NPIX);
        check("done_fdone", frame_done, 1);
        check("done_valid", out_valid, 0);
        check("done_busy", busy, 1);
        check("done_last", out_last, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        x_0 = '0; x_step = '0; y_0 = '0; y_step = '0;
        repeat (2) @(negedge clk);
        check_quiet("rst");
        check("rst_x", out_x, 0);
        check("rst_y", out_y, 0);
        check("rst_col", out_col, 0);
        check("rst_row", out_row, 0);
        reset = 1'b0;
        @(negedge clk);
        check_quiet("idle");

`ifdef JULIA_COORD_AUTO_RESTART_EN
        x_0 = 27'h7800000; x_step = 27'h0200000; y_0 = 27'h0800000; y_step = 27'h7C00000;
        start_frame();
        collect_frame(0, 0, 27'h7800000, 27'h0200000, 27'h0800000, 27'h7C00000);
        // new live x_0 is picked up at the DONE re-latch
        x_0 = 27'h0400000;
        @(negedge clk);
        collect_frame(1, 0, 27'h0400000, 27'h0200000, 27'h0800000, 27'h7C00000);
        @(negedge clk);
        collect_frame(0, 0, 27'h0400000, 27'h0200000, 27'h0800000, 27'h7C00000);
        @(negedge clk);
        check("auto4_valid", out_valid, 1);
        check("auto4_col", out_col, 0);
        check("auto4_x", out_x, 27'h0400000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_quiet("auto_rst");
        @(negedge clk);
        check_quiet("auto_rst_idle");
`else
        // basic frame
        x_0 = 27'h7800000; x_step = 27'h0200000; y_0 = 27'h0800000; y_step = 27'h7C00000;
        start_frame();
        collect_frame(0, 0, 27'h7800000, 27'h0200000, 27'h0800000, 27'h7C00000);
        @(negedge clk);
        check_quiet("post1");
        @(negedge clk);
        check_quiet("post1b");

        // backpressure
        start_frame();
        collect_frame(1, 0, 27'h7800000, 27'h0200000, 27'h0800000, 27'h7C00000);
        @(negedge clk);
        check_quiet("post2");

        // wrap-around: second pixel wraps to most negative
        x_0 = 27'h3FFFFFF; x_step = 27'h0000001; y_0 = 27'h0; y_step = 27'h0;
        start_frame();
        check("wrap_x0", out_x, 27'h3FFFFFF);
        @(negedge clk);
        check("wrap_x1", out_x, 27'h4000000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // parameter isolation: x_0 and start changed at beat 5 do not disturb the frame
        x_0 = 27'h0100000; x_step = 27'h0200000; y_0 = 27'h0800000; y_step = 27'h7C00000;
        start_frame();
        collect_frame(0, 1, 27'h0100000, 27'h0200000, 27'h0800000, 27'h7C00000);
        @(negedge clk);
        check_quiet("post_iso");
        start_frame();
        collect_frame(0, 0, 27'h0223456, 27'h0200000, 27'h0800000, 27'h7C00000);
        @(negedge clk);

        // reset at beat 5
        start_frame();
        repeat (5) @(negedge clk);
        check("pre_rst_col", out_col, 1);
        check("pre_rst_row", out_row, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_quiet("midrst");
        check("midrst_x", out_x, 0);
        check("midrst_col", out_col, 0);
        repeat (3) begin
            @(negedge clk);
            check_quiet("midrst_after");
        end
        start_frame();
        collect_frame(0, 0, 27'h0223456, 27'h0200000, 27'h0800000, 27'h7C00000);
        @(negedge clk);
        check_quiet("final");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
